// File: rtl/qr_pkg.sv
// Shared constants, FSM state type and bit-placement helper for the QR codeword packer.
package qr_pkg;

   localparam int unsigned NUM_CW    = 44;
   localparam int unsigned CW_W      = 8;
   localparam logic [3:0]  BYTE_MODE = 4'b0100;

   localparam int unsigned FRAME_W = NUM_CW * CW_W;
   localparam int unsigned BYTE_W  = $clog2(NUM_CW);
   localparam int unsigned BIT_W   = $clog2(CW_W);
   localparam int unsigned IDX_W   = $clog2(FRAME_W);

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StCheck,
      StDeliver,
      StHalt
   } state_e;

   // First-received bit of a codeword lands in its MSB.
   function automatic logic [IDX_W-1:0] cw_bit_index(input logic [BYTE_W-1:0] byte_idx,
                                                     input logic [BIT_W-1:0]  bit_idx);
      int unsigned idx;
      idx = CW_W * 32'(byte_idx) + (CW_W - 1) - 32'(bit_idx);
      return IDX_W'(idx);
   endfunction

endpackage

// File: rtl/cw_bit_counter.sv
// Bit-within-codeword and codeword counters for the serial packer, with clear and last-bit flag.
module cw_bit_counter
   import qr_pkg::*;
(
   input  logic              clk,
   input  logic              srstn,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [BIT_W-1:0]  bit_cnt_o,
   output logic [BYTE_W-1:0] byte_cnt_o,
   output logic              last_o
);

   logic [BIT_W-1:0]  bit_cnt_d, bit_cnt_q;
   logic [BYTE_W-1:0] byte_cnt_d, byte_cnt_q;
   logic              bit_wrap;

   assign bit_wrap = (bit_cnt_q == BIT_W'(CW_W - 1));

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      if (clr_i) begin
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
      end else if (inc_i) begin
         if (bit_wrap) begin
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
         end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign bit_cnt_o  = bit_cnt_q;
   assign byte_cnt_o = byte_cnt_q;
   assign last_o     = bit_wrap && (byte_cnt_q == BYTE_W'(NUM_CW - 1));

endmodule

// File: rtl/cw_pack.sv
// Serial-to-parallel packer: assembles one 44-codeword QR frame and holds it for the text decoder.
module cw_pack
   import qr_pkg::*;
(
   input  logic               clk,
   input  logic               srstn,
   input  logic               frame_start,
   input  logic               bit_valid,
   input  logic               bit_in,
   output logic               bit_ready,
   output logic [FRAME_W-1:0] codeword,
   output logic               de_text_valid,
   input  logic               qr_decode_finish,
   output logic               mode_err,
   output logic               frame_done
);

   state_e state_d, state_q;

   logic [FRAME_W-1:0] codeword_d, codeword_q;
   logic               mode_err_d, mode_err_q;
   logic               frame_done_d, frame_done_q;

   logic [BIT_W-1:0]   bit_cnt;
   logic [BYTE_W-1:0]  byte_cnt;
   logic               last_bit;
   logic               start_clr;
   logic               accept;
   logic               mode_ok;

   // CHECK lasts a single cycle and is not abortable.
   assign start_clr = frame_start && (state_q != StCheck);
   assign accept    = (state_q == StCollect) && bit_valid && !frame_start;
   assign mode_ok   = (codeword_q[7:4] == BYTE_MODE);

   cw_bit_counter u_cnt (
      .clk        (clk),
      .srstn      (srstn),
      .clr_i      (start_clr),
      .inc_i      (accept),
      .bit_cnt_o  (bit_cnt),
      .byte_cnt_o (byte_cnt),
      .last_o     (last_bit)
   );

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (frame_start) state_d = StCollect;
         end
         StCollect: begin
            if (frame_start) begin
               state_d = StCollect;
            end else if (accept && last_bit) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            state_d = mode_ok ? StDeliver : StHalt;
         end
         StDeliver: begin
            if (frame_start) begin
               state_d = StCollect;
            end else if (qr_decode_finish) begin
               state_d = StIdle;
            end
         end
         StHalt: begin
            if (frame_start) state_d = StCollect;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bit_ready     = (state_q == StCollect);
      de_text_valid = (state_q == StDeliver);
   end

   always_comb begin
      codeword_d   = codeword_q;
      mode_err_d   = mode_err_q;
      frame_done_d = 1'b0;
      if (start_clr) begin
         codeword_d = '0;
         mode_err_d = 1'b0;
      end else begin
         if (accept) begin
            codeword_d[cw_bit_index(byte_cnt, bit_cnt)] = bit_in;
         end
         if ((state_q == StCheck) && !mode_ok) begin
            mode_err_d = 1'b1;
         end
         if ((state_q == StDeliver) && qr_decode_finish) begin
            frame_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         codeword_q   <= '0;
         mode_err_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         codeword_q   <= codeword_d;
         mode_err_q   <= mode_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign codeword   = codeword_q;
   assign mode_err   = mode_err_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cw_pack.sv
// Directed/randomized bench for cw_pack against a byte-array frame model.
module tb_cw_pack;
   import qr_pkg::*;

   logic               clk = 1'b0;
   logic               srstn;
   logic               frame_start;
   logic               bit_valid;
   logic               bit_in;
   logic               bit_ready;
   logic [FRAME_W-1:0] codeword;
   logic               de_text_valid;
   logic               qr_decode_finish;
   logic               mode_err;
   logic               frame_done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]         fb [NUM_CW];
   logic [FRAME_W-1:0] exp_cw;

   cw_pack dut (
      .clk              (clk),
      .srstn            (srstn),
      .frame_start      (frame_start),
      .bit_valid        (bit_valid),
      .bit_in           (bit_in),
      .bit_ready        (bit_ready),
      .codeword         (codeword),
      .de_text_valid    (de_text_valid),
      .qr_decode_finish (qr_decode_finish),
      .mode_err         (mode_err),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FRAME_W-1:0] obs,
                        input logic [FRAME_W-1:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Byte k of the frame model occupies codeword[8k+7:8k].
   task automatic build_exp();
      exp_cw = '0;
      for (int k = 0; k < NUM_CW; k++) exp_cw[k*CW_W +: CW_W] = fb[k];
   endtask

   task automatic fill_fixed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] rest);
      fb[0] = b0;
      fb[1] = b1;
      for (int k = 2; k < NUM_CW; k++) fb[k] = rest;
      build_exp();
   endtask

   task automatic fill_random(input logic [7:0] b0);
      fb[0] = b0;
      for (int k = 1; k < NUM_CW; k++) fb[k] = 8'($urandom);
      build_exp();
   endtask

   // Sends model bits [first, last) in reading order, MSB of each byte first.
   task automatic send_range(input int first, input int last, input bit gapped);
      logic [7:0] cur;
      for (int i = first; i < last; i++) begin
         if (gapped) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
               bit_valid = 1'b0;
               bit_in    = 1'($urandom);
               step();
            end
         end
         cur       = fb[i / CW_W];
         bit_valid = 1'b1;
         bit_in    = cur[CW_W - 1 - (i % CW_W)];
         step();
      end
      bit_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_codeword"}, codeword, '0);
      check({tag, "_bit_ready"}, bit_ready, 1'b0);
      check({tag, "_de_text_valid"}, de_text_valid, 1'b0);
      check({tag, "_mode_err"}, mode_err, 1'b0);
      check({tag, "_frame_done"}, frame_done, 1'b0);
   endtask

   initial begin
      srstn            = 1'b0;
      frame_start      = 1'b0;
      bit_valid        = 1'b0;
      bit_in           = 1'b0;
      qr_decode_finish = 1'b0;
      #12;
      check_reset_outputs("reset");
      #5 srstn = 1'b1;
      step();

      // Nominal frame, with a stray finish during COLLECT.
      fill_fixed(8'h40, 8'h3A, 8'hC3);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("nom_bit_ready", bit_ready, 1'b1);
      send_range(0, 50, 1'b0);
      qr_decode_finish = 1'b1;
      step();
      qr_decode_finish = 1'b0;
      check("collect_finish_done", frame_done, 1'b0);
      check("collect_finish_ready", bit_ready, 1'b1);
      send_range(50, FRAME_W, 1'b0);
      check("nom_check_valid", de_text_valid, 1'b0);
      check("nom_check_ready", bit_ready, 1'b0);
      step();
      check("nom_valid_n2", de_text_valid, 1'b1);
      check("nom_cw0", codeword[7:0], 8'h40);
      check("nom_cw1", codeword[15:8], 8'h3A);
      check("nom_frame", codeword, exp_cw);
      check("nom_mode_err", mode_err, 1'b0);
      step();
      check("nom_hold_valid", de_text_valid, 1'b1);
      qr_decode_finish = 1'b1;
      step();
      qr_decode_finish = 1'b0;
      check("fin_done", frame_done, 1'b1);
      check("fin_valid", de_text_valid, 1'b0);
      check("fin_ready", bit_ready, 1'b0);
      step();
      check("fin_done_pulse", frame_done, 1'b0);

      // Bad mode nibble.
      fill_random(8'h20);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      send_range(0, FRAME_W, 1'b0);
      step();
      check("bad_mode_err", mode_err, 1'b1);
      check("bad_valid", de_text_valid, 1'b0);
      qr_decode_finish = 1'b1;
      step();
      qr_decode_finish = 1'b0;
      check("halt_finish_done", frame_done, 1'b0);
      repeat (3) step();
      check("halt_mode_err", mode_err, 1'b1);
      check("halt_ready", bit_ready, 1'b0);
      check("halt_valid", de_text_valid, 1'b0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("halt_exit_err", mode_err, 1'b0);
      check("halt_exit_ready", bit_ready, 1'b1);

      // Gapped input of the nominal frame, then junk offered while not ready.
      fill_fixed(8'h40, 8'h3A, 8'hC3);
      send_range(0, FRAME_W, 1'b1);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      step();
      check("gap_valid", de_text_valid, 1'b1);
      bit_in = 1'b0;
      step();
      bit_in = 1'b1;
      step();
      bit_valid = 1'b0;
      check("gap_frame", codeword, exp_cw);

      // frame_start and finish together in DELIVER.
      frame_start      = 1'b1;
      qr_decode_finish = 1'b1;
      step();
      frame_start      = 1'b0;
      qr_decode_finish = 1'b0;
      check("sim_done", frame_done, 1'b0);
      check("sim_ready", bit_ready, 1'b1);
      check("sim_valid", de_text_valid, 1'b0);
      check("sim_cleared", codeword, '0);
      step();
      check("sim_done_late", frame_done, 1'b0);

      // Abort after 100 bits; the restart cycle carries a bit that must be dropped.
      fill_random(8'h4F);
      send_range(0, 100, 1'b0);
      fill_random({4'h4, 4'($urandom)});
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_in      = 1'b1;
      step();
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      check("abort_cleared", codeword, '0);
      send_range(0, FRAME_W, 1'b1);
      step();
      check("abort_valid", de_text_valid, 1'b1);
      check("abort_frame", codeword, exp_cw);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("dabort_valid", de_text_valid, 1'b0);
      check("dabort_done", frame_done, 1'b0);
      check("dabort_ready", bit_ready, 1'b1);
      step();
      check("dabort_done_late", frame_done, 1'b0);

      // Async reset during COLLECT.
      fill_random(8'h41);
      send_range(0, 30, 1'b0);
      #2 srstn = 1'b0;
      #1;
      check_reset_outputs("arst_collect");
      #3 srstn = 1'b1;
      step();
      fill_random({4'h4, 4'($urandom)});
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      send_range(0, FRAME_W, 1'b0);
      step();
      check("post_arst_valid", de_text_valid, 1'b1);
      check("post_arst_frame", codeword, exp_cw);

      // Async reset during DELIVER.
      #2 srstn = 1'b0;
      #1;
      check_reset_outputs("arst_deliver");
      #3 srstn = 1'b1;
      step();
      fill_random({4'h4, 4'($urandom)});
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      send_range(0, FRAME_W, 1'b1);
      step();
      check("final_frame", codeword, exp_cw);
      qr_decode_finish = 1'b1;
      step();
      qr_decode_finish = 1'b0;
      check("final_done", frame_done, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
